// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, returning the
// unscaled magnitude (gain ~1.6468) and atan2 phase in binary-angle units.
module cordic_vectoring #(
  parameter int WIDTH      = 9,
  parameter int ITERATIONS = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic        [WIDTH+1:0] magnitude,
  output logic signed [WIDTH-1:0] phase,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int XW = WIDTH + 2;
  localparam int ZW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic signed [XW-1:0] r_x;
  logic signed [XW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic        [3:0]    r_iter;
  logic                 r_zero;
  logic        [XW-1:0] r_mag;
  logic        [WIDTH-1:0] r_phase;

  logic signed [XW-1:0] w_xExt;
  logic signed [XW-1:0] w_yExt;
  logic signed [XW-1:0] w_xPre;
  logic signed [XW-1:0] w_yPre;
  logic signed [ZW-1:0] w_zPre;
  logic signed [XW-1:0] w_xShift;
  logic signed [XW-1:0] w_yShift;
  logic signed [ZW-1:0] w_atan;
  logic signed [XW-1:0] w_xNext;
  logic signed [XW-1:0] w_yNext;
  logic signed [ZW-1:0] w_zNext;
  logic                 w_lastIter;

  function automatic logic signed [ZW-1:0] atanEntry(input logic [3:0] idx);
    case (idx)
      4'd0:    atanEntry = ZW'(64);
      4'd1:    atanEntry = ZW'(38);
      4'd2:    atanEntry = ZW'(20);
      4'd3:    atanEntry = ZW'(10);
      4'd4:    atanEntry = ZW'(5);
      4'd5:    atanEntry = ZW'(3);
      4'd6:    atanEntry = ZW'(1);
      4'd7:    atanEntry = ZW'(1);
      default: atanEntry = '0;
    endcase
  endfunction

  // Two guard bits let -(-256) be represented exactly and hold the ~596 worst case.
  assign w_xExt = {{2{x_in[WIDTH-1]}}, x_in};
  assign w_yExt = {{2{y_in[WIDTH-1]}}, y_in};

  always_comb begin
    w_xPre = w_xExt;
    w_yPre = w_yExt;
    w_zPre = '0;
    if (w_xExt[XW-1]) begin
      if (!w_yExt[XW-1]) begin
        w_xPre = w_yExt;
        w_yPre = -w_xExt;
        w_zPre = ZW'(128);
      end else begin
        w_xPre = -w_yExt;
        w_yPre = w_xExt;
        w_zPre = -ZW'(128);
      end
    end
  end

  assign w_xShift   = r_x >>> r_iter;
  assign w_yShift   = r_y >>> r_iter;
  assign w_atan     = atanEntry(r_iter);
  assign w_lastIter = (r_iter == 4'(ITERATIONS - 1));

  always_comb begin
    w_xNext = r_x - w_yShift;
    w_yNext = r_y + w_xShift;
    w_zNext = r_z - w_atan;
    if (!r_y[XW-1]) begin
      w_xNext = r_x + w_yShift;
      w_yNext = r_y - w_xShift;
      w_zNext = r_z + w_atan;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = ITER;
      end
      ITER: begin
        if (w_lastIter) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Results are latched on the final micro-rotation so they stay frozen in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      r_zero  <= 1'b0;
      r_mag   <= '0;
      r_phase <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x    <= w_xPre;
            r_y    <= w_yPre;
            r_z    <= w_zPre;
            r_iter <= '0;
            r_zero <= (x_in == '0) && (y_in == '0);
          end
        end
        ITER: begin
          r_x    <= w_xNext;
          r_y    <= w_yNext;
          r_z    <= w_zNext;
          r_iter <= r_iter + 4'd1;
          if (w_lastIter) begin
            r_mag   <= r_zero ? '0 : $unsigned(w_xNext);
            r_phase <= r_zero ? '0 : w_zNext[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign magnitude = r_mag;
  assign phase     = r_phase;

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
Iterative CORDIC in vectoring mode: takes a signed (x, y) vector and returns its unscaled magnitude and phase (atan2). It is the inverse companion of the rotation-mode sine/cosine pipeline, using the same 9-bit signed data format, the same binary-angle units (256 = 180°) and the same arctangent table. One CORDIC micro-rotation is done per clock, with valid/ready handshakes on both input and output.

Parameters:
WIDTH, 9, signed input width and phase output width.
ITERATIONS, 9, number of micro-rotations; legal range 1..9, limited by the table size.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
x_in  input  WIDTH  signed x component
y_in  input  WIDTH  signed y component
in_valid  input  1  x_in/y_in are valid
in_ready  output  1  block can accept a vector
magnitude  output  WIDTH+2  unsigned result; includes the CORDIC gain of about 1.6468
phase  output  WIDTH  signed binary angle; 256 = 180°, 128 = 90°
out_valid  output  1  magnitude/phase are valid
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset: asynchronous and active-high. It forces state IDLE, in_ready=1, out_valid=0, magnitude=0, phase=0 and clears all internal registers. Asserting reset mid-operation aborts the computation and discards the result.
- Internal datapath:
  - x and y are WIDTH+2 bits signed (11 bits by default).
  - z is WIDTH+1 bits signed.
  - Shifts are arithmetic (>>> i).
- Arctangent table, indices 0..8: 64, 38, 20, 10, 5, 3, 1, 1, 0.
- State machine:
  - IDLE: in_ready=1. On in_valid & in_ready, capture the inputs sign-extended, apply pre-rotation, set iter=0 and go to ITER.
  - ITER: in_ready=0. Each cycle performs micro-rotation iter, then iter increments. After iteration ITERATIONS-1, go to DONE.
  - DONE: out_valid=1. Outputs hold stable while out_ready=0. On out_valid & out_ready go to IDLE; in_ready rises on the next cycle.
- Pre-rotation, so that x is at least 0 before the iterations:
  - x ≥ 0: (x, y) unchanged, z0 = 0.
  - x < 0 and y ≥ 0: (x, y) becomes (y, -x), z0 = +128.
  - x < 0 and y < 0: (x, y) becomes (-y, x), z0 = -128.
- Micro-rotation i:
  - If y ≥ 0: x += y>>>i, y -= x>>>i, z += atan[i].
  - Otherwise: x -= y>>>i, y += x>>>i, z -= atan[i].
  - All three updates use the pre-update values.
- Outputs, registered on entry to DONE:
  - magnitude = final x, as unsigned WIDTH+2 bits.
  - phase = low WIDTH bits of final z, i.e. wrap modulo 512, so +256 reads as -256.
- Zero vector (x_in = 0 and y_in = 0): the block still runs the full latency, but forces magnitude=0 and phase=0.
- Extreme inputs: negating -256 is exact because of the internal headroom. The worst-case magnitude, about 596, fits without overflow.
- Latency: accept edge T; iteration edges T+1 to T+ITERATIONS; out_valid is high after edge T+ITERATIONS. Minimum throughput is one result per ITERATIONS+2 cycles.
- in_valid is ignored outside IDLE. Input changes during ITER or DONE have no effect.

Test Plan:
- Reset asserted asynchronously with no clock edge: in_ready=1, out_valid=0, magnitude=0, phase=0 immediately.
- (x_in, y_in) = (100, 0) → phase 0 ±1, magnitude 165 ±2. out_valid rises exactly 9 cycles after the accept edge.
- Quadrant checks, each phase ±2:
  - (0, 100) → phase 128, magnitude 165 ±2.
  - (100, 100) → phase 64, magnitude 233 ±3.
  - (-100, -100) → phase -192.
  - (-100, 0) → phase -256 (wrap of +256), also accepting 254/255.
- Zero and extreme inputs: (0, 0) → magnitude 0, phase 0. (-256, -256) → magnitude 596 ±4, no overflow, phase -192 ±2.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 throughout. Outputs stay stable, in_ready stays 0 and no second capture occurs. Releasing out_ready → IDLE, and the next vector is accepted one cycle later.
- Reset pulse during iteration 4: out_valid never rises for that vector. After reset is released, a new vector (50, -50) → phase -64 ±2.
